// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
// The op encoding is also used by the instruction decoder.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    function automatic logic op_signed(input op_t o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_t o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit_negate_cond.sv
// Conditional two's-complement negation: y = neg ? -x : x.
// Used for operand magnitudes and result sign correction.
module negate_cond #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? -x : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// One shift-add or restoring shift-subtract step per cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    op_t                op_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               neg_q;
    logic               neg_r;
    logic               bz_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    op_t              op_in;
    logic             sgn_in;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign op_in  = op_t'(op);
    assign sgn_in = op_signed(op_in);

    negate_cond #(.WIDTH(WIDTH)) u_abs_a (
        .x(a), .neg(sgn_in & a[WIDTH-1]), .y(abs_a)
    );
    negate_cond #(.WIDTH(WIDTH)) u_abs_b (
        .x(b), .neg(sgn_in & b[WIDTH-1]), .y(abs_b)
    );

    // acc: multiply = {partial, multiplier}; divide = {rem, dividend}
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;

    assign sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    assign trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign ge    = trial >= {1'b0, opnd};
    assign diff  = trial - {1'b0, opnd};

    assign mul_next = {sum, acc[WIDTH-1:1]};
    assign div_next = {(ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0]),
                       acc[WIDTH-2:0], ge};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    negate_cond #(.WIDTH(2*WIDTH)) u_fix_p (
        .x(acc), .neg(neg_q), .y(prod_fix)
    );
    negate_cond #(.WIDTH(WIDTH)) u_fix_q (
        .x(acc[WIDTH-1:0]), .neg(neg_q), .y(quo_fix)
    );
    negate_cond #(.WIDTH(WIDTH)) u_fix_r (
        .x(acc[2*WIDTH-1:WIDTH]), .neg(neg_r), .y(rem_fix)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            op_q   <= OP_MULT;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            bz_q   <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op_in;
                        cnt   <= '0;
                        opnd  <= op_is_div(op_in) ? abs_b : abs_a;
                        acc   <= {{WIDTH{1'b0}},
                                  (op_is_div(op_in) ? abs_a : abs_b)};
                        neg_q <= sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r <= sgn_in & a[WIDTH-1];
                        bz_q  <= (b == '0);
                        state <= RUN;
                    end else begin
                        if (hi_we) hi_q <= wd;
                        if (lo_we) lo_q <= wd;
                    end
                end
                RUN: begin
                    acc <= op_is_div(op_q) ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIN;
                end
                FIN: begin
                    // zero divisor leaves remainder = |a|, re-signed to a
                    if (!op_is_div(op_q)) begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= bz_q ? {WIDTH{1'b1}} : quo_fix;
                    end
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit.
// Results are compared with a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wd = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o,
                                  input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] h, output logic [31:0] l);
        logic signed [63:0] ps;
        logic [63:0] pu;
        int sx, sy;
        sx = x;
        sy = y;
        h = '0;
        l = '0;
        case (o)
            2'b00: begin
                ps = 64'(longint'(sx) * longint'(sy));
                h = ps[63:32];
                l = ps[31:0];
            end
            2'b01: begin
                pu = 64'(x) * 64'(y);
                h = pu[63:32];
                l = pu[31:0];
            end
            2'b10: begin
                if (y == 0) begin
                    l = 32'hFFFF_FFFF;
                    h = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000;
                    h = 32'h0;
                end else begin
                    l = sx / sy;
                    h = sx % sy;
                end
            end
            default: begin
                if (y == 0) begin
                    l = 32'hFFFF_FFFF;
                    h = x;
                end else begin
                    l = x / y;
                    h = x % y;
                end
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input string tag);
        logic [31:0] eh, el, h0, l0;
        int cyc;
        bit stable;
        model(o, x, y, eh, el);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        h0 = hi;
        l0 = lo;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        cyc = 0;
        stable = 1'b1;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!done && (hi !== h0 || lo !== l0)) stable = 1'b0;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'd33);
        chk({tag, "_stable"}, 64'(stable), 64'd1);
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [31:0] rx, ry, h0;
        logic [1:0] ro;
        int dn;

        #12;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        @(negedge clk);
        hi_we = 1'b1;
        wd = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b1;
        wd = 32'h9ABC_DEF0;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mthi", 64'(hi), 64'h1234_5678);
        chk("mtlo", 64'(lo), 64'h9ABC_DEF0);
        chk("mt_busy", 64'(busy), 64'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_hi", 64'(hi), 64'd0);
        chk("async_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(2'b00, 32'hFFFF_FFFE, 32'h3, "mult");
        run_op(2'b01, 32'hFFFF_FFFE, 32'h3, "multu");
        run_op(2'b10, 32'hFFFF_FFF9, 32'h2, "div");
        run_op(2'b11, 32'h7, 32'h2, "divu");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(2'b11, 32'h55, 32'h0, "divu_z");
        run_op(2'b10, 32'hFFFF_FFF0, 32'h0, "div_z");

        // busy blocking: start with MTHI in the same cycle, then extra requests
        h0 = hi;
        @(negedge clk);
        start = 1'b1;
        op = 2'b01;
        a = 32'd5;
        b = 32'd6;
        hi_we = 1'b1;
        wd = 32'hDEAD;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        chk("sw_drop", 64'(hi), 64'(h0));
        dn = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (i == 3) begin
                start = 1'b1;
                op = 2'b10;
                a = 32'd99;
                b = 32'd4;
                hi_we = 1'b1;
                lo_we = 1'b1;
                wd = 32'hDEAD;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        chk("blk_done", 64'(dn), 64'd1);
        chk("blk_hi", 64'(hi), 64'd0);
        chk("blk_lo", 64'(lo), 64'd30);

        // reset mid-operation
        @(negedge clk);
        start = 1'b1;
        op = 2'b11;
        a = 32'd100;
        b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_hi", 64'(hi), 64'd0);
        chk("mid_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        chk("mid_nodone", 64'(dn), 64'd0);
        run_op(2'b11, 32'd100, 32'd7, "post_rst");

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'h0;
                1: ry = 32'hFFFF_FFFF;
                2: ry = $urandom_range(1, 15);
                default: ry = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
            run_op(ro, rx, ry, $sformatf("rnd%0d_op%0d", i, ro));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
